// File: rtl/pipeline_reg_pkg.sv
// rtl/pipeline_reg_pkg.sv - shared types and constants for the branch target table
package pipeline_reg_pkg;

    localparam int BPT_IDX_W   = 4;
    localparam int BPT_ENTRIES = 1 << BPT_IDX_W;
    localparam int BPT_TAG_W   = 32 - BPT_IDX_W - 2;

    localparam logic [1:0] BRA_NONE = 2'b00;
    localparam logic [1:0] BRA_BNE  = 2'b01;
    localparam logic [1:0] BRA_BEQ  = 2'b10;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [BPT_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } bpt_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter next-state function
module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != 2'b11) ctr_o = ctr_i + 2'b01;
        end else begin
            if (ctr_i != 2'b00) ctr_o = ctr_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target table with EX/MEM training
module branch_predictor
    import pipeline_reg_pkg::*;
#(
    parameter int ENTRIES = BPT_ENTRIES,
    parameter int IDX_W   = BPT_IDX_W,
    parameter int TAG_W   = 32 - IDX_W - 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic [1:0]       upd_bra,
    input  logic             upd_zero,
    input  logic [IDX_W-1:0] upd_index,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    output logic             mispredict,
    output logic [31:0]      correct_pc,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    bpt_entry_t tbl_q [ENTRIES];
    bpt_entry_t tbl_d [ENTRIES];
    logic [31:0] branches_q, branches_d;
    logic [31:0] mispred_q, mispred_d;

    bpt_entry_t       look_e;
    logic [IDX_W-1:0] look_idx;
    logic             look_hit;

    // Lookup: reset is folded in so fetch never sees a stale prediction mid-reset.
    assign look_idx = lookup_pc[IDX_W+1:2];
    assign look_e   = tbl_q[look_idx];
    assign look_hit = look_e.valid && (look_e.tag == lookup_pc[31:IDX_W+2]);

    assign pred_index  = look_idx;
    assign pred_taken  = !RST && look_hit && look_e.ctr[1];
    assign pred_target = pred_taken ? look_e.target : lookup_pc + 32'd4;

    logic is_br, taken, upd_en, upd_hit;
    bpt_entry_t upd_e;
    logic [1:0] ctr_next;

    assign is_br = (upd_bra == BRA_BNE) || (upd_bra == BRA_BEQ);
    assign taken = ((upd_bra == BRA_BNE) && !upd_zero) ||
                   ((upd_bra == BRA_BEQ) &&  upd_zero);

    assign mispredict = is_br && (taken != upd_pred_taken);
    assign correct_pc = taken ? upd_target : upd_pc + 32'd4;

    assign upd_en  = is_br && !stall;
    assign upd_e   = tbl_q[upd_index];
    assign upd_hit = upd_e.valid && (upd_e.tag == upd_pc[31:IDX_W+2]);

    sat_counter2 u_ctr (
        .ctr_i (upd_e.ctr),
        .inc_i (taken),
        .ctr_o (ctr_next)
    );

    always_comb begin
        tbl_d      = tbl_q;
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (upd_en) begin
            if (upd_hit) begin
                tbl_d[upd_index].ctr    = ctr_next;
                tbl_d[upd_index].target = upd_target;
            end else if (taken) begin
                tbl_d[upd_index].valid  = 1'b1;
                tbl_d[upd_index].tag    = upd_pc[31:IDX_W+2];
                tbl_d[upd_index].target = upd_target;
                tbl_d[upd_index].ctr    = CTR_ALLOC;
            end
            branches_d = sat_inc32(branches_q);
            if (mispredict) mispred_d = sat_inc32(mispred_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            tbl_q      <= tbl_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed plus randomized checks against a table model
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_index;
    logic [1:0]  upd_bra = 2'b00;
    logic        upd_zero = 1'b0;
    logic [3:0]  upd_index = '0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor dut (
        .CLK(CLK), .RST(RST), .stall(stall), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index),
        .upd_bra(upd_bra), .upd_zero(upd_zero), .upd_index(upd_index),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Model: each slot remembers the full PC that owns it and a 0..3 confidence.
    bit          m_valid  [16];
    int unsigned m_owner  [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    longint      m_br = 0;
    longint      m_mp = 0;
    bit          known = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = slot_of(pc);
        return m_valid[s] && ((m_owner[s] / 64) == (pc / 64));
    endfunction

    function automatic bit outcome(input logic [1:0] bra, input logic z);
        if (bra == 2'd1) return !z;
        if (bra == 2'd2) return z;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_owner[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mp = 0;
    endtask

    task automatic settle();
        bit br, tk, pt;
        logic [31:0] pc4;
        int s;
        #2;
        s  = slot_of(lookup_pc);
        pt = !RST && m_hit(lookup_pc) && (m_ctr[s] >= 2);
        br = (upd_bra == 2'd1) || (upd_bra == 2'd2);
        tk = outcome(upd_bra, upd_zero);
        pc4 = lookup_pc + 32'd4;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, pt});
        check("pred_target", pred_target, pt ? m_target[s] : pc4);
        check("pred_index", {28'd0, pred_index}, s);
        check("mispredict", {31'd0, mispredict}, {31'd0, br && (tk != upd_pred_taken)});
        check("correct_pc", correct_pc, tk ? upd_target : upd_pc + 32'd4);
        if (known) begin
            check("stat_branches", stat_branches, m_br[31:0]);
            check("stat_mispredicts", stat_mispredicts, m_mp[31:0]);
        end
    endtask

    task automatic tick();
        bit br, tk, mp, do_rst, en;
        int s;
        do_rst = RST;
        br = (upd_bra == 2'd1) || (upd_bra == 2'd2);
        tk = outcome(upd_bra, upd_zero);
        mp = br && (tk != upd_pred_taken);
        en = br && !stall;
        s  = int'(upd_index);
        @(posedge CLK);
        if (do_rst) begin
            model_reset();
            known = 1;
        end else if (en) begin
            if (m_valid[s] && (m_owner[s] / 64) == (upd_pc / 64)) begin
                m_ctr[s] = tk ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                              : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
                m_target[s] = upd_target;
            end else if (tk) begin
                m_valid[s] = 1; m_owner[s] = upd_pc; m_target[s] = upd_target; m_ctr[s] = 2;
            end
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
        end
        #1;
    endtask

    task automatic set_upd(input logic [1:0] bra, input logic z, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic pt);
        upd_bra = bra; upd_zero = z; upd_pc = pc; upd_index = pc[5:2];
        upd_target = tgt; upd_pred_taken = pt;
    endtask

    logic [31:0] br_save, mp_save;

    initial begin
        model_reset();
        RST = 1; lookup_pc = 32'h40; set_upd(2'b00, 0, 0, 0, 0);
        settle(); tick();
        settle(); tick();
        RST = 0;

        settle();
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h44);
        check("rst_stats", stat_branches | stat_mispredicts, 32'd0);
        tick();

        set_upd(2'b10, 1, 32'h40, 32'h100, 0);
        settle();
        check("beq_mispredict", {31'd0, mispredict}, 32'd1);
        check("beq_correct_pc", correct_pc, 32'h100);
        tick();
        set_upd(2'b00, 0, 0, 0, 0);
        settle();
        check("alloc_pred_target", pred_target, 32'h100);
        check("alloc_stat_br", stat_branches, 32'd1);
        check("alloc_stat_mp", stat_mispredicts, 32'd1);
        tick();

        for (int k = 0; k < 3; k++) begin
            set_upd(2'b10, 0, 32'h40, 32'h100, 1);
            settle(); tick();
            set_upd(2'b00, 0, 0, 0, 0);
            settle();
            check("nt_pred_taken", {31'd0, pred_taken}, 32'd0);
        end

        lookup_pc = 32'h80;
        settle();
        check("alias_miss_target", pred_target, 32'h84);
        set_upd(2'b01, 0, 32'h80, 32'h200, 0);
        settle(); tick();
        set_upd(2'b00, 0, 0, 0, 0);
        settle();
        check("alias_new_target", pred_target, 32'h200);
        lookup_pc = 32'h40;
        settle();
        check("alias_old_miss", pred_target, 32'h44);

        br_save = stat_branches; mp_save = stat_mispredicts;
        stall = 1; lookup_pc = 32'h44;
        set_upd(2'b01, 0, 32'h44, 32'h300, 0);
        settle();
        check("stall_mispredict", {31'd0, mispredict}, 32'd1);
        tick();
        set_upd(2'b00, 0, 0, 0, 0);
        settle();
        check("stall_stat_br", stat_branches, br_save);
        check("stall_no_alloc", pred_target, 32'h48);
        stall = 0;
        set_upd(2'b01, 0, 32'h44, 32'h300, 0);
        settle(); tick();
        set_upd(2'b00, 0, 0, 0, 0);
        settle();
        check("unstall_target", pred_target, 32'h300);
        check("unstall_stat_mp", stat_mispredicts, mp_save + 32'd1);

        set_upd(2'b11, 1, 32'h40, 32'h500, 0);
        settle();
        check("bra11_mispredict", {31'd0, mispredict}, 32'd0);
        tick();

        RST = 1; lookup_pc = 32'h80;
        set_upd(2'b01, 0, 32'h80, 32'h600, 0);
        settle(); tick();
        RST = 0; set_upd(2'b00, 0, 0, 0, 0);
        settle();
        check("rst_upd_pred", {31'd0, pred_taken}, 32'd0);
        check("rst_upd_stats", stat_branches | stat_mispredicts, 32'd0);
        tick();

        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            lookup_pc = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
            pc = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
            set_upd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pc,
                    $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) upd_index = 4'($urandom_range(0, 15));
            stall = ($urandom_range(0, 7) == 0);
            RST = ($urandom_range(0, 99) == 0);
            settle(); tick();
        end
        RST = 0; stall = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
